// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter with branch/load/call/return and return-address stack
// Optional feature: PROGRAM_SEQUENCER_STACK_WRAP_EN (full-stack Call overwrites the oldest entry)
module program_sequencer #(
    parameter int WIDTH        = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Stall,
    input  logic [WIDTH-1:0]                   LoadValue,
    input  logic                               LoadEnable,
    input  logic [OFFSET_WIDTH-1:0]            Offset,
    input  logic                               OffsetEnable,
    input  logic                               Call,
    input  logic                               Return,
    output logic [WIDTH-1:0]                   CounterValue,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   StackCount,
    output logic                               StackOverflow,
    output logic                               StackUnderflow
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] stack [STACK_DEPTH];
    // ptr is the next write slot; the top of stack lives one slot below it (circularly)
    logic [PW-1:0]    ptr, ptr_next, ptr_inc, ptr_dec;
    logic [WIDTH-1:0] pc_next, pc_inc;
    logic [CW-1:0]    count_next;
    logic             ovf_next, unf_next, push, full;

    assign pc_inc  = CounterValue + WIDTH'(1);
    assign ptr_inc = (ptr == PW'(STACK_DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(STACK_DEPTH - 1) : ptr - PW'(1);
    assign full    = (StackCount == CW'(STACK_DEPTH));

    always_comb begin
        pc_next    = pc_inc;
        count_next = StackCount;
        ptr_next   = ptr;
        ovf_next   = StackOverflow;
        unf_next   = StackUnderflow;
        push       = 1'b0;
        if (Call) begin
            pc_next = LoadValue;
            if (!full) begin
                push       = 1'b1;
                ptr_next   = ptr_inc;
                count_next = StackCount + CW'(1);
            end else begin
                ovf_next = 1'b1;
`ifdef PROGRAM_SEQUENCER_STACK_WRAP_EN
                push     = 1'b1;
                ptr_next = ptr_inc;
`endif
            end
        end else if (Return) begin
            if (StackCount != '0) begin
                pc_next    = stack[ptr_dec];
                ptr_next   = ptr_dec;
                count_next = StackCount - CW'(1);
            end else begin
                unf_next = 1'b1;
            end
        end else if (LoadEnable) begin
            pc_next = LoadValue;
        end else if (OffsetEnable) begin
            pc_next = CounterValue + WIDTH'($signed(Offset));
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            CounterValue   <= '0;
            StackCount     <= '0;
            ptr            <= '0;
            StackOverflow  <= 1'b0;
            StackUnderflow <= 1'b0;
        end else if (!Stall) begin
            CounterValue   <= pc_next;
            StackCount     <= count_next;
            ptr            <= ptr_next;
            StackOverflow  <= ovf_next;
            StackUnderflow <= unf_next;
        end
    end

    // Stack contents are not reset; StackCount alone defines which entries are valid
    always_ff @(posedge Clock) begin
        if (!Reset && !Stall && push) begin
            stack[ptr] <= pc_inc;
        end
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the program-counter width in bits.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 9, the signed branch-offset width in bits.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, the number of return-stack entries (>=2).
REQ-004 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Stall  input  1  freezes all state this cycle.
REQ-007 SHALL have port LoadValue  input  WIDTH  absolute jump or call target.
REQ-008 SHALL have port LoadEnable  input  1  absolute jump request.
REQ-009 SHALL have port Offset  input  OFFSET_WIDTH  signed relative-branch offset.
REQ-010 SHALL have port OffsetEnable  input  1  relative branch request.
REQ-011 SHALL have port Call  input  1  push return address, jump to LoadValue.
REQ-012 SHALL have port Return  input  1  pop return address into counter.
REQ-013 SHALL have port CounterValue  output  WIDTH  current program counter, registered.
REQ-014 SHALL have port StackCount  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-015 SHALL have port StackOverflow  output  1  sticky flag, set by a Call on a full stack.
REQ-016 SHALL have port StackUnderflow  output  1  sticky flag, set by a Return on an empty stack.

Function
REQ-017 SHALL apply per-cycle priority: Reset > Stall > Call > Return > LoadEnable > OffsetEnable > increment.
REQ-018 SHALL hold CounterValue, stack, StackCount and flags unchanged while Stall=1 and Reset=0.
REQ-019 SHALL, on Call, push CounterValue+1 (mod 2^WIDTH), set CounterValue<=LoadValue, and increment StackCount.
REQ-020 SHALL, on Return with StackCount>0, set CounterValue<=top entry and decrement StackCount.
REQ-021 SHALL, on Return with StackCount=0, set CounterValue<=CounterValue+1, leave StackCount at 0 and set StackUnderflow.
REQ-022 SHALL ignore Return, LoadEnable and OffsetEnable when Call=1 in the same cycle.
REQ-023 SHALL, on LoadEnable, set CounterValue<=LoadValue.
REQ-024 SHALL, on OffsetEnable, set CounterValue<=CounterValue+sign-extended Offset, with the result truncated mod 2^WIDTH.
REQ-025 SHALL otherwise set CounterValue<=CounterValue+1, wrapping from all-ones to 0.
REQ-026 SHALL make every update visible on CounterValue one cycle after the controlling inputs are sampled (latency 1).
REQ-027 SHALL keep StackOverflow and StackUnderflow set until Reset.
REQ-028 SHALL keep the stack a LIFO: entries are returned in reverse push order.

Reset
REQ-029 SHALL, when Reset=1 at a rising edge, set CounterValue=0, StackCount=0, StackOverflow=0 and StackUnderflow=0, regardless of other inputs.
REQ-030 SHALL treat stack contents as invalid after Reset; they need not be cleared.
REQ-031 SHALL let Reset asserted mid-call-sequence discard all pending return addresses.

Configuration
REQ-032 SHALL honour macro PROGRAM_SEQUENCER_STACK_WRAP_EN.
- Defined: a Call on a full stack overwrites the oldest entry (circular), pushes the new return address, keeps StackCount=STACK_DEPTH and sets StackOverflow.
- Undefined: a Call on a full stack still jumps to LoadValue, but discards the push, keeps StackCount=STACK_DEPTH and sets StackOverflow.

Verification
REQ-033 Reset 2 cycles, release, 5 idle cycles -> CounterValue=5.
REQ-034 LoadEnable=1, LoadValue=16'hF0F0 for 1 cycle -> 16'hF0F0, then 16'hF0F1 on the next cycle.
REQ-035 Branch and wrap:
- PC=16'h0010, OffsetEnable=1, Offset=9'h1FE (-2) -> 16'h000E.
- PC=16'hFFFF, idle -> 16'h0000.
REQ-036 PC=16'h0020, Call with LoadValue=16'h0100 -> 16'h0100, StackCount=1; 3 idle cycles, then Return -> 16'h0021, StackCount=0.
REQ-037 STACK_DEPTH=4, 5 consecutive Calls from PCs A..E, then 5 Returns:
- Both builds: StackOverflow=1 and StackCount=4 after the 5th Call; the 5th Return gives StackUnderflow=1 and PC+1.
- Macro undefined: the first 4 Returns yield D+1, C+1, B+1, A+1.
- Macro defined: the first 4 Returns yield E+1, D+1, C+1, B+1.
REQ-038 Stall=1 with Call=1, LoadEnable=1 and OffsetEnable=1 for 3 cycles -> CounterValue, StackCount and flags unchanged; Reset=1 with Stall=1 -> all outputs 0.
